axi_lite_req_arbiter: RTL and testbench
=======================================

# axi_lite_req_arbiter

Round-robin arbiter that shares one AXI-Lite master (start_read/start_write pulse interface) between NUM_REQ requesters. It accepts one request at a time, issues the matching start pulse with the latched address/data, and monitors the AXI response handshake to detect completion. It then returns read data and a one-cycle done pulse to the owning requester. It sits between user-side bus clients and the AXI-Lite master.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 32: address width
- DATA_W, 32: data width

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request; held high until req_ready
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  flattened; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid; 0 for writes
- start_read  out  1  one-cycle pulse to master
- start_write  out  1  one-cycle pulse to master
- m_addr  out  ADDR_W  address to master
- m_data  out  DATA_W  write data to master
- RVALID, RREADY, BVALID, BREADY  in  1 each  monitored AXI handshake signals, read only
- RDATA  in  DATA_W  monitored read data
- busy  out  1  high in any state except IDLE
- owner  out  $clog2(NUM_REQ)  index of current/last granted requester

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, the winner is the first set bit searching from rr_ptr upward with wrap. req_ready[winner]=1 combinationally this cycle. At the edge:
  - latch addr, wdata and write into the owner registers
  - owner <= winner
  - rr_ptr <= winner+1, mod NUM_REQ
  - go to ISSUE
- No req_valid in IDLE: stay; req_ready all zero.
- ISSUE, one cycle, registered outputs:
  - start_write=1 if latched write, else start_read=1; never both.
  - m_addr/m_data driven from latch; held stable through WAIT and RESP.
  - Go to WAIT.
- WAIT: read completes on RVALID&&RREADY; write completes on BVALID&&BREADY. Handshakes of the other type are ignored. On completion, capture RDATA (reads) or 0 (writes) into the rsp_rdata register, then go to RESP. No timeout; WAIT holds indefinitely.
- RESP, one cycle: rsp_valid[owner]=1, then go to IDLE.
- rr_ptr updates only on grant. A requester that drops req_valid before grant is simply skipped.
- Reset, including mid-transaction, forces:
  - state IDLE, rr_ptr=0, owner=0, latches 0
  - all outputs 0: req_ready, rsp_valid, rsp_rdata, start_*, m_addr, m_data, busy

## Timing
- Request seen at cycle t gets req_ready in cycle t and the start pulse in t+1.
- Earliest completion handshake is in t+2. Completion at cycle c gives rsp_valid in c+1.
- The next grant is at the earliest c+2. This guarantees the master has returned to its idle state first.
- Minimum transaction: 4 cycles from grant to re-arbitration.
- rsp_rdata holds its value until the next completion.
- m_addr/m_data are valid in the start-pulse cycle; the master samples them on that edge.
- busy is high from t+1 through the RESP cycle.

## Test plan
- Write: req 0 write addr 0x10, data 0xDEADBEEF.
  - req_ready[0] at t; start_write=1 at t+1 with m_addr=0x10, m_data=0xDEADBEEF.
  - BVALID&&BREADY at t+3 -> rsp_valid[0] at t+4, rsp_rdata=0.
- Read: req 2 read 0x20, slave returns RDATA=0x12345678.
  - Expect start_read at t+1, then rsp_valid[2] with rsp_rdata=0x12345678 one cycle after the R handshake.
- Contention: req 0, 1 and 3 all held from reset. Grants must come in order 0, 1, 3. Re-asserting req 0 during the others' transactions gives order 0, 1, 3, 0.
- Stray handshake: during a write WAIT, pulse RVALID&&RREADY. No completion may occur; completion follows only the later BVALID&&BREADY.
- Reset mid-WAIT: assert areset_n=0 asynchronously. All outputs must be 0 immediately. After release, a new req 1 is granted first because rr_ptr=0 scans 0 then 1.
- Dropped request: req 2 pulses for one cycle while the arbiter is busy. No grant is given to 2, and no rsp_valid[2] occurs.

Source files
------------

// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master (start pulse interface) among NUM_REQ clients.
// One transaction in flight; completion is detected by monitoring the R/B handshakes.
module axi_lite_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                       aclk,
  input  logic                       areset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       start_read,
  output logic                       start_write,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       RVALID,
  input  logic                       RREADY,
  input  logic                       BVALID,
  input  logic                       BREADY,
  input  logic [DATA_W-1:0]          RDATA,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               start_read_q, start_read_d;
  logic               start_write_q, start_write_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   idx;
  logic               done;

  // First requesting index at or above rr_ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Only the handshake matching the latched direction completes the transaction.
  assign done = write_q ? (BVALID && BREADY) : (RVALID && RREADY);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    start_read_d  = 1'b0;
    start_write_d = 1'b0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d       = winner;
          rr_ptr_d      = IDX_W'((32'(winner) + 32'd1) % NUM_REQ);
          write_d       = req_write[winner];
          addr_d        = req_addr[32'(winner)*ADDR_W +: ADDR_W];
          wdata_d       = req_wdata[32'(winner)*DATA_W +: DATA_W];
          start_write_d = req_write[winner];
          start_read_d  = !req_write[winner];
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done) begin
          rsp_rdata_d          = write_q ? '0 : RDATA;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      start_read_q  <= 1'b0;
      start_write_q <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      start_read_q  <= start_read_d;
      start_write_q <= start_write_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  // Grant is combinational; masked by reset so all outputs read 0 while it is asserted.
  assign req_ready   = (areset_n && state_q == S_IDLE && found) ? (NUM_REQ'(1) << winner) : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign start_read  = start_read_q;
  assign start_write = start_write_q;
  assign m_addr      = addr_q;
  assign m_data      = wdata_q;
  assign busy        = (state_q != S_IDLE);
  assign owner       = owner_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter: single-transaction vector table plus
// hand-written sequences for contention, stray handshakes, reset and dropped requests.
module tb_axi_lite_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            aclk = 1'b0;
  logic            areset_n;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, m_data, RDATA;
  logic [AW-1:0]   m_addr;
  logic            start_read, start_write, busy;
  logic            RVALID, RREADY, BVALID, BREADY;
  logic [1:0]      owner;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_lite_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .start_read(start_read), .start_write(start_write), .m_addr(m_addr), .m_data(m_data),
    .RVALID(RVALID), .RREADY(RREADY), .BVALID(BVALID), .BREADY(BREADY), .RDATA(RDATA),
    .busy(busy), .owner(owner)
  );

  typedef struct {
    int          r;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slv_rdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive point: 1 time unit after the rising edge; sampling happens 2 units later.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rspv"},  32'(rsp_valid), 32'h0);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_srd"},   32'(start_read), 32'h0);
    chk({tag, "_swr"},   32'(start_write), 32'h0);
    chk({tag, "_maddr"}, m_addr, 32'h0);
    chk({tag, "_mdata"}, m_data, 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
    chk({tag, "_owner"}, 32'(owner), 32'h0);
  endtask

  // One full transaction from an idle arbiter; entered and left at a sample point.
  task automatic run_vec(input vec_t v);
    step();
    req_valid[v.r] = 1'b1;
    req_write[v.r] = v.wr;
    req_addr[v.r*AW +: AW]  = v.addr;
    req_wdata[v.r*DW +: DW] = v.wdata;
    #2;
    chk("vec_ready", 32'(req_ready), 32'h1 << v.r);
    chk("vec_busy_t", 32'(busy), 32'h0);
    step();
    req_valid[v.r] = 1'b0;
    #2;
    chk("vec_start_wr", 32'(start_write), 32'(v.wr));
    chk("vec_start_rd", 32'(start_read), 32'(!v.wr));
    chk("vec_maddr", m_addr, v.addr);
    if (v.wr) chk("vec_mdata", m_data, v.wdata);
    chk("vec_owner", 32'(owner), 32'(v.r));
    chk("vec_busy_t1", 32'(busy), 32'h1);
    for (int k = 0; k < v.lat; k++) begin
      step();
      #2;
      chk("vec_wait_rspv", 32'(rsp_valid), 32'h0);
      chk("vec_wait_start", 32'({start_read, start_write}), 32'h0);
    end
    step();
    RDATA = v.slv_rdata;
    if (v.wr) begin BVALID = 1'b1; BREADY = 1'b1; end
    else      begin RVALID = 1'b1; RREADY = 1'b1; end
    #2;
    chk("vec_cmpl_rspv", 32'(rsp_valid), 32'h0);
    step();
    RVALID = 1'b0; RREADY = 1'b0; BVALID = 1'b0; BREADY = 1'b0;
    RDATA  = 32'hBAD0BAD0;
    #2;
    chk("vec_rspv", 32'(rsp_valid), 32'h1 << v.r);
    chk("vec_rdata", rsp_rdata, v.exp_rdata);
    chk("vec_busy_resp", 32'(busy), 32'h1);
    step();
    #2;
    chk("vec_idle_busy", 32'(busy), 32'h0);
    chk("vec_idle_rspv", 32'(rsp_valid), 32'h0);
    chk("vec_rdata_hold", rsp_rdata, v.exp_rdata);
  endtask

  // Waits (bounded) for a grant, checks it went to exp_idx, completes it as a read.
  task automatic grant_and_complete(input int exp_idx, input logic [N-1:0] set_mask);
    int           n;
    logic [N-1:0] g;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      step();
      #2;
      n++;
    end
    chk("rr_grant", 32'(req_ready), 32'h1 << exp_idx);
    g = req_ready;
    step();
    req_valid = (req_valid & ~g) | set_mask;
    #2;
    chk("rr_start_rd", 32'(start_read), 32'h1);
    chk("rr_owner", 32'(owner), 32'(exp_idx));
    step();
    RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'hA0 + 32'(exp_idx);
    #2;
    step();
    RVALID = 1'b0; RREADY = 1'b0;
    #2;
    chk("rr_rspv", 32'(rsp_valid), 32'h1 << exp_idx);
    chk("rr_rdata", rsp_rdata, 32'hA0 + 32'(exp_idx));
    step();
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{r: 0, wr: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF, slv_rdata: 32'hFFFFFFFF, lat: 1, exp_rdata: 32'h0};
    vecs[1] = '{r: 2, wr: 1'b0, addr: 32'h20, wdata: 32'h0,        slv_rdata: 32'h12345678, lat: 0, exp_rdata: 32'h12345678};
    vecs[2] = '{r: 3, wr: 1'b0, addr: 32'h3C, wdata: 32'h0,        slv_rdata: 32'hCAFEF00D, lat: 3, exp_rdata: 32'hCAFEF00D};
    vecs[3] = '{r: 1, wr: 1'b1, addr: 32'h44, wdata: 32'h0BADF00D, slv_rdata: 32'h55AA55AA, lat: 0, exp_rdata: 32'h0};

    areset_n  = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    RVALID = 1'b0; RREADY = 1'b0; BVALID = 1'b0; BREADY = 1'b0; RDATA = '0;
    step(); step();
    #2;
    chk_all_zero("reset");
    step();
    areset_n = 1'b1;
    #2;
    chk("post_reset_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Contention: 0, 1 and 3 held through reset; 0 re-asserted during 1's transaction.
    areset_n  = 1'b0;
    req_write = '0;
    req_valid = 4'b1011;
    step(); step();
    #2;
    chk("cont_reset_ready", 32'(req_ready), 32'h0);
    step();
    areset_n = 1'b1;
    #2;
    grant_and_complete(0, 4'b0000);
    grant_and_complete(1, 4'b0001);
    grant_and_complete(3, 4'b0000);
    grant_and_complete(0, 4'b0000);

    // Reset while waiting on a read; pending 1 and 3 must go to 1 after reset.
    step();
    req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2*AW +: AW] = 32'h24;
    #2;
    chk("rst_ready2", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    #2;
    step();
    req_valid = 4'b1010;
    #2;
    chk("rst_wait_busy", 32'(busy), 32'h1);
    chk("rst_wait_ready", 32'(req_ready), 32'h0);
    areset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    areset_n = 1'b1;
    #2;
    grant_and_complete(1, 4'b0000);
    grant_and_complete(3, 4'b0000);

    // Stray R handshake during a write's WAIT must not complete it.
    step();
    req_valid[1] = 1'b1; req_write[1] = 1'b1;
    req_addr[1*AW +: AW] = 32'h80; req_wdata[1*DW +: DW] = 32'h11112222;
    #2;
    chk("stray_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    #2;
    chk("stray_start_wr", 32'(start_write), 32'h1);
    chk("stray_mdata", m_data, 32'h11112222);
    step();
    RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'h99999999;
    #2;
    step();
    RVALID = 1'b0; RREADY = 1'b0;
    #2;
    chk("stray_no_rspv", 32'(rsp_valid), 32'h0);
    chk("stray_busy", 32'(busy), 32'h1);
    step();
    #2;
    chk("stray_no_rspv2", 32'(rsp_valid), 32'h0);
    step();
    BVALID = 1'b1; BREADY = 1'b1;
    #2;
    step();
    BVALID = 1'b0; BREADY = 1'b0;
    #2;
    chk("stray_rspv", 32'(rsp_valid), 32'h2);
    chk("stray_rdata", rsp_rdata, 32'h0);
    step();
    #2;
    chk("stray_idle", 32'(busy), 32'h0);

    // Requester 2 pulses for one cycle while busy: never granted, never answered.
    step();
    req_valid[0] = 1'b1; req_write[0] = 1'b0;
    #2;
    chk("drop_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0100;
    #2;
    chk("drop_busy_ready", 32'(req_ready), 32'h0);
    step();
    req_valid = '0;
    RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'h00000077;
    #2;
    step();
    RVALID = 1'b0; RREADY = 1'b0;
    #2;
    chk("drop_rspv0", 32'(rsp_valid), 32'h1);
    chk("drop_rdata", rsp_rdata, 32'h77);
    for (int k = 0; k < 4; k++) begin
      step();
      #2;
      chk("drop_no_ready", 32'(req_ready), 32'h0);
      chk("drop_no_rspv", 32'(rsp_valid), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
